progmem_loader: RTL
===================

Name: progmem_loader

Overview:
Writable 16x8 program store for the TD4 core, replacing the fixed ROM on the CPU's A/D fetch bus. A byte-stream load port with a valid/ready handshake fills the store, and an optional trailing checksum validates the image. CPU_HOLD keeps the core in reset until a complete, validated image is present. The CPU side is an asynchronous read with the same timing as a ROM.

Parameters:
AW, 4, address width; depth is 2**AW words.
DW, 8, data/instruction width.
CHECKSUM, 1, 1 = one checksum byte follows the image; 0 = no checksum byte.

Ports:
CLK  input  1  system clock; all state changes on its rising edge.
CLR  input  1  reset, asynchronous, active-high.
A  input  AW  CPU fetch address.
D  output  DW  instruction to CPU.
LD_START  input  1  single-cycle strobe that begins or restarts a load.
LD_VALID  input  1  LD_DATA is valid.
LD_DATA  input  DW  image byte or checksum byte.
LD_READY  output  1  loader accepts a byte this cycle.
LD_COUNT  output  AW+1  number of image bytes written in the current load.
LD_DONE  output  1  one-cycle pulse when the image becomes valid.
LD_ERR  output  1  held high when a checksum mismatch is detected.
CPU_HOLD  output  1  active-high reset request to the CPU.

Behaviour:
- States: IDLE, LOAD, CHECK, RUN, ERROR. Internal registers: wptr (AW+1 bits), sum (DW bits, modulo 2**DW), mem[2**AW].
- Reset (CLR=1, asynchronous): state=IDLE, wptr=0, sum=0. Output values during reset: LD_READY=0, LD_COUNT=0, LD_DONE=0, LD_ERR=0, CPU_HOLD=1, D=0. mem contents are not reset.
- D is combinational: D=mem[A] in RUN; D=0 in every other state.
- CPU_HOLD=0 only in RUN. It is registered from the state, so it rises or falls in the cycle after the state changes.
- LD_READY=1 only in LOAD and CHECK. A byte transfers on a rising edge where LD_VALID=1, LD_READY=1 and LD_START=0.
- LD_COUNT=wptr.
- LD_START=1 (sampled in any state): next state=LOAD, wptr=0, sum=0, LD_ERR=0. Any byte offered in the same cycle is dropped. LD_START is the only exit from IDLE, RUN and ERROR.
- LOAD, on each transfer: mem[wptr]=LD_DATA, sum=sum+LD_DATA (wrap), wptr+=1.
  - On the transfer that makes wptr=2**AW: next state=CHECK if CHECKSUM=1, else RUN with LD_DONE=1 for exactly one cycle.
- CHECK, on one transfer: if LD_DATA==sum, next state=RUN and LD_DONE pulses; otherwise next state=ERROR and LD_ERR=1 until the next LD_START or CLR.
- LD_VALID=0 gaps of any length stall the load and cause no state change.
- LD_VALID in IDLE, RUN or ERROR is ignored, and mem is never written in those states.
- CLR asserted mid-load aborts the load: state=IDLE and CPU_HOLD=1. Partial mem contents are never exposed on D, because D=0 outside RUN.
- A reload from RUN immediately re-asserts CPU_HOLD (next cycle), so the CPU never fetches a partially written image.

Test Plan:
- Reset: hold CLR=1 for 2 cycles -> CPU_HOLD=1, LD_READY=0, LD_COUNT=0, D=0x00 for every A.
- Good load: LD_START, then bytes 0x00..0x0F back-to-back, then checksum 0x78 -> LD_DONE pulses once, CPU_HOLD=0 next cycle, D=A for A=0..15.
- Bad checksum: same image, checksum 0x77 -> LD_ERR=1, CPU_HOLD stays 1, D=0. A subsequent LD_START clears LD_ERR and sets LD_COUNT=0.
- Stalls and drop: random LD_VALID gaps across a full load -> LD_COUNT advances only on transfers and the final contents match. LD_START together with LD_VALID (byte 0xAA) -> 0xAA is not written and LD_COUNT=0.
- Restart/abort: LD_START after 5 bytes -> LD_COUNT=0 and the load completes normally. CLR asserted after 9 bytes -> IDLE immediately, LD_READY=0.
- CHECKSUM=0: load 16 bytes -> RUN right after byte 16, with no checksum byte accepted. With the TD4 core attached, the core leaves reset only after LD_DONE.

Source files
------------

// File: rtl/progmem_loader.sv
// progmem_loader: writable 16x8 program store for the TD4 core, filled over a byte-stream
// load port with an optional trailing checksum; holds the CPU in reset until the image is valid.
module progmem_loader #(
    parameter int AW = 4,
    parameter int DW = 8,
    parameter bit CHECKSUM = 1'b1
) (
    input  logic          CLK,
    input  logic          CLR,
    input  logic [AW-1:0] A,
    output logic [DW-1:0] D,
    input  logic          LD_START,
    input  logic          LD_VALID,
    input  logic [DW-1:0] LD_DATA,
    output logic          LD_READY,
    output logic [AW:0]   LD_COUNT,
    output logic          LD_DONE,
    output logic          LD_ERR,
    output logic          CPU_HOLD
);
    typedef enum logic [2:0] {IDLE, LOAD, CHECK, RUN, ERROR} state_t;
    state_t        state_q;
    logic [AW:0]   wptr_q;
    logic [DW-1:0] sum_q, sum_d;
    logic [DW-1:0] mem [2**AW];
    logic          xfer, wr, last, sum_ok;

    assign LD_READY = (state_q == LOAD) || (state_q == CHECK);
    assign xfer     = LD_VALID && LD_READY && !LD_START;
    assign wr       = xfer && (state_q == LOAD);
    assign last     = wptr_q[AW-1:0] == '1;
    assign sum_d    = sum_q + LD_DATA;
    assign sum_ok   = LD_DATA == sum_q;
    assign LD_COUNT = wptr_q;
    // Partial or failed images never reach the CPU: D reads zero outside RUN.
    assign D        = (state_q == RUN) ? mem[A] : '0;

    always_ff @(posedge CLK)
        if (wr) mem[wptr_q[AW-1:0]] <= LD_DATA;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q  <= IDLE;
            wptr_q   <= '0;
            sum_q    <= '0;
            LD_DONE  <= 1'b0;
            LD_ERR   <= 1'b0;
            CPU_HOLD <= 1'b1;
        end else begin
            LD_DONE  <= 1'b0;
            CPU_HOLD <= state_q != RUN;
            if (LD_START) begin
                state_q <= LOAD;
                wptr_q  <= '0;
                sum_q   <= '0;
                LD_ERR  <= 1'b0;
            end else if (wr) begin
                wptr_q <= wptr_q + 1'b1;
                sum_q  <= sum_d;
                if (last) begin
                    state_q <= CHECKSUM ? CHECK : RUN;
                    LD_DONE <= !CHECKSUM;
                end
            end else if (xfer) begin
                state_q <= sum_ok ? RUN : ERROR;
                LD_DONE <= sum_ok;
                LD_ERR  <= !sum_ok;
            end
        end
    end
endmodule
